// File: rtl/ex_mem_stage.sv
// LEGv8 execute stage: operand forwarding, ALU/shifter, branch-target adder,
// NZVC flag register and the EX/MEM pipeline register feeding MEM.
module ex_mem_stage #(
    parameter int         W   = 64,
    parameter logic [4:0] XZR = 5'd31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         flush,
    input  logic [W-1:0] RD1,
    input  logic [W-1:0] RD2,
    input  logic [W-1:0] PCaddr,
    input  logic [W-1:0] se,
    input  logic [4:0]   Rn,
    input  logic [4:0]   Rm,
    input  logic [4:0]   Rd,
    input  logic [5:0]   cntrl_EX,
    input  logic [4:0]   cntrl_M,
    input  logic [1:0]   cntrl_WB,
    input  logic [W-1:0] mem_fwd_data,
    input  logic [4:0]   mem_Rd,
    input  logic         mem_RegWrite,
    input  logic [W-1:0] wb_fwd_data,
    input  logic [4:0]   wb_Rd,
    input  logic         wb_RegWrite,
    output logic [W-1:0] alu_result_o,
    output logic [W-1:0] store_data_o,
    output logic [W-1:0] br_target_o,
    output logic         zero_o,
    output logic [3:0]   flags_o,
    output logic [4:0]   Rd_o,
    output logic [4:0]   cntrl_M_o,
    output logic [1:0]   cntrl_WB_o
);
    localparam int SHW = $clog2(W);

    logic         alu_src, shift_dir, flag_en;
    logic [2:0]   alu_op;
    logic [W-1:0] fwd_a, fwd_b, alu_b, b_add, alu_res, br_target;
    logic [W:0]   sum;
    logic         alu_c, alu_v;

    assign {alu_src, shift_dir, flag_en, alu_op} = cntrl_EX;

    // MEM result is younger than WB, so it wins when both target the source
    always_comb begin
        fwd_a = RD1;
        if (mem_RegWrite && mem_Rd == Rn && Rn != XZR)
            fwd_a = mem_fwd_data;
        else if (wb_RegWrite && wb_Rd == Rn && Rn != XZR)
            fwd_a = wb_fwd_data;
    end

    always_comb begin
        fwd_b = RD2;
        if (mem_RegWrite && mem_Rd == Rm && Rm != XZR)
            fwd_b = mem_fwd_data;
        else if (wb_RegWrite && wb_Rd == Rm && Rm != XZR)
            fwd_b = wb_fwd_data;
    end

    assign alu_b     = alu_src ? se : fwd_b;
    assign br_target = PCaddr + {se[W-3:0], 2'b00};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        b_add   = '0;
        sum     = '0;
        case (alu_op)
            3'b000: alu_res = alu_b;
            3'b010, 3'b011: begin
                // subtract as A + ~B + 1 so C is the ARM-style not-borrow
                b_add   = alu_op[0] ? ~alu_b : alu_b;
                sum     = {1'b0, fwd_a} + {1'b0, b_add} + {{W{1'b0}}, alu_op[0]};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (fwd_a[W-1] == b_add[W-1]) && (sum[W-1] != fwd_a[W-1]);
            end
            3'b100: alu_res = fwd_a & alu_b;
            3'b101: alu_res = fwd_a | alu_b;
            3'b110: alu_res = fwd_a ^ alu_b;
            3'b111: alu_res = shift_dir ? (fwd_a >> se[SHW-1:0]) : (fwd_a << se[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_o <= 4'b0000;
        else if (enable && flag_en && !flush)
            flags_o <= {alu_res[W-1], alu_res == '0, alu_c, alu_v};
    end

    // flush only kills the control fields; the data payload is don't-care downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_o <= '0;
            store_data_o <= '0;
            br_target_o  <= '0;
            zero_o       <= 1'b0;
            Rd_o         <= '0;
            cntrl_M_o    <= '0;
            cntrl_WB_o   <= '0;
        end else if (enable) begin
            alu_result_o <= alu_res;
            store_data_o <= fwd_b;
            br_target_o  <= br_target;
            zero_o       <= (fwd_b == '0);
            Rd_o         <= Rd;
            cntrl_M_o    <= flush ? 5'b0 : cntrl_M;
            cntrl_WB_o   <= flush ? 2'b0 : cntrl_WB;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_mem_stage;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, enable, flush;
    logic [W-1:0] RD1, RD2, PCaddr, se, mem_fwd_data, wb_fwd_data;
    logic [4:0]   Rn, Rm, Rd, mem_Rd, wb_Rd;
    logic [5:0]   cntrl_EX;
    logic [4:0]   cntrl_M;
    logic [1:0]   cntrl_WB;
    logic         mem_RegWrite, wb_RegWrite;
    logic [W-1:0] alu_result_o, store_data_o, br_target_o;
    logic         zero_o;
    logic [3:0]   flags_o;
    logic [4:0]   Rd_o, cntrl_M_o;
    logic [1:0]   cntrl_WB_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    ex_mem_stage #(.W(W), .XZR(5'd31)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .RD1(RD1), .RD2(RD2), .PCaddr(PCaddr), .se(se),
        .Rn(Rn), .Rm(Rm), .Rd(Rd),
        .cntrl_EX(cntrl_EX), .cntrl_M(cntrl_M), .cntrl_WB(cntrl_WB),
        .mem_fwd_data(mem_fwd_data), .mem_Rd(mem_Rd), .mem_RegWrite(mem_RegWrite),
        .wb_fwd_data(wb_fwd_data), .wb_Rd(wb_Rd), .wb_RegWrite(wb_RegWrite),
        .alu_result_o(alu_result_o), .store_data_o(store_data_o),
        .br_target_o(br_target_o), .zero_o(zero_o), .flags_o(flags_o),
        .Rd_o(Rd_o), .cntrl_M_o(cntrl_M_o), .cntrl_WB_o(cntrl_WB_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] pick(input logic [4:0] idx, input logic [W-1:0] rf);
        if (idx == 5'd31) return rf;
        if (mem_RegWrite && mem_Rd == idx) return mem_fwd_data;
        if (wb_RegWrite && wb_Rd == idx) return wb_fwd_data;
        return rf;
    endfunction

    function automatic void alu_model(input logic [2:0] op, input logic dir,
                                      input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [5:0] sh, output logic [W-1:0] r,
                                      output logic c, output logic v);
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0: r = b;
            3'd1: r = '0;
            3'd2: begin
                r = a + b;
                c = (r < a);
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = dir ? (a >> sh) : (a << sh);
        endcase
    endfunction

    logic [W-1:0] m_alu, m_st, m_br;
    logic         m_z;
    logic [3:0]   m_flags;
    logic [4:0]   m_rd, m_cm;
    logic [1:0]   m_cwb;

    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] a, b, r;
        logic c, v;
        if (rst) begin
            m_alu <= '0; m_st <= '0; m_br <= '0; m_z <= 1'b0;
            m_flags <= '0; m_rd <= '0; m_cm <= '0; m_cwb <= '0;
        end else if (enable) begin
            a = pick(Rn, RD1);
            b = pick(Rm, RD2);
            alu_model(cntrl_EX[2:0], cntrl_EX[4], a, cntrl_EX[5] ? se : b, se[5:0], r, c, v);
            m_alu <= r;
            m_st  <= b;
            m_z   <= (b == 0);
            m_br  <= PCaddr + se * 4;
            m_rd  <= Rd;
            m_cm  <= flush ? 5'd0 : cntrl_M;
            m_cwb <= flush ? 2'd0 : cntrl_WB;
            if (cntrl_EX[3] && !flush)
                m_flags <= {r[W-1], r == 0, c, v};
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("alu_result", alu_result_o, m_alu);
            check("store_data", store_data_o, m_st);
            check("br_target", br_target_o, m_br);
            check("zero", W'(zero_o), W'(m_z));
            check("flags", W'(flags_o), W'(m_flags));
            check("Rd", W'(Rd_o), W'(m_rd));
            check("cntrl_M", W'(cntrl_M_o), W'(m_cm));
            check("cntrl_WB", W'(cntrl_WB_o), W'(m_cwb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [2:0] aop, input logic src, input logic dir, input logic fen);
        cntrl_EX = {src, dir, fen, aop};
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"}, alu_result_o, '0);
        check({tag, "_st"}, store_data_o, '0);
        check({tag, "_br"}, br_target_o, '0);
        check({tag, "_misc"}, W'({zero_o, flags_o, Rd_o, cntrl_M_o, cntrl_WB_o}), '0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        RD1 = '0; RD2 = '0; PCaddr = '0; se = '0;
        Rn = 5'd1; Rm = 5'd2; Rd = 5'd3;
        cntrl_EX = '0; cntrl_M = '0; cntrl_WB = '0;
        mem_fwd_data = '0; mem_Rd = '0; mem_RegWrite = 1'b0;
        wb_fwd_data = '0; wb_Rd = '0; wb_RegWrite = 1'b0;
        cyc();
        check_all_zero("reset_init");
        rst = 1'b0; chk_en = 1'b1; enable = 1'b1;

        // plain add, no forwarding
        RD1 = 64'd5; RD2 = 64'd7; op(3'b010, 1'b0, 1'b0, 1'b0);
        cyc(); check("add_nofwd", alu_result_o, 64'd12);

        // MEM beats WB on Rn
        mem_RegWrite = 1'b1; mem_Rd = 5'd1; mem_fwd_data = 64'd100;
        wb_RegWrite = 1'b1; wb_Rd = 5'd1; wb_fwd_data = 64'd200;
        cyc(); check("fwd_mem_prio", alu_result_o, 64'd107);

        // XZR never forwarded
        Rn = 5'd31; mem_Rd = 5'd31; wb_Rd = 5'd31;
        cyc(); check("xzr_nofwd", alu_result_o, 64'd12);
        mem_RegWrite = 1'b0; wb_RegWrite = 1'b0; Rn = 5'd1;

        RD1 = 64'd3; RD2 = 64'd5; op(3'b011, 1'b0, 1'b0, 1'b1);
        cyc(); check("sub_neg", alu_result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_neg_flags", W'(flags_o), W'(4'b1000));

        RD1 = 64'd5;
        cyc(); check("sub_zero", alu_result_o, 64'd0);
        check("sub_zero_flags", W'(flags_o), W'(4'b0110));

        RD1 = 64'h7FFF_FFFF_FFFF_FFFF; RD2 = 64'd1; op(3'b010, 1'b0, 1'b0, 1'b1);
        cyc(); check("add_ovf", alu_result_o, 64'h8000_0000_0000_0000);
        check("add_ovf_flags", W'(flags_o), W'(4'b1001));

        RD1 = 64'd1; se = 64'd63; op(3'b111, 1'b0, 1'b0, 1'b0);
        cyc(); check("lsl63", alu_result_o, 64'h8000_0000_0000_0000);
        check("flags_kept", W'(flags_o), W'(4'b1001));

        RD1 = 64'h8000_0000_0000_0000; op(3'b111, 1'b0, 1'b1, 1'b0);
        cyc(); check("lsr63", alu_result_o, 64'd1);

        // stall: outputs frozen while inputs churn
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RD1 = {$urandom, $urandom}; RD2 = {$urandom, $urandom};
            op(3'b010, 1'b0, 1'b0, 1'b1); cntrl_M = 5'h1F;
            cyc(); check("stall_hold", alu_result_o, 64'd1);
            check("stall_flags", W'(flags_o), W'(4'b1001));
        end
        enable = 1'b1; RD1 = 64'd5; RD2 = 64'd7; op(3'b010, 1'b0, 1'b0, 1'b0);
        cyc(); check("stall_release", alu_result_o, 64'd12);
        check("cm_load", W'(cntrl_M_o), W'(5'h1F));

        // flush with flag update requested
        flush = 1'b1; RD1 = 64'd5; RD2 = 64'd5; op(3'b011, 1'b0, 1'b0, 1'b1);
        cntrl_M = 5'b11111; cntrl_WB = 2'b11;
        cyc(); check("flush_cm", W'(cntrl_M_o), 0);
        check("flush_cwb", W'(cntrl_WB_o), 0);
        check("flush_flags", W'(flags_o), W'(4'b1001));
        check("flush_data", alu_result_o, 64'd0);
        flush = 1'b0;

        PCaddr = 64'h100; se = '1; op(3'b000, 1'b0, 1'b0, 1'b0);
        cyc(); check("br_target", br_target_o, 64'hFC);

        // reset mid-stall/flush, between edges
        enable = 1'b0; flush = 1'b1;
        #2 rst = 1'b1;
        #1 check_all_zero("reset_async");
        #1 rst = 1'b0;
        enable = 1'b1; flush = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] idx [5];
            idx = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
            enable = ($urandom_range(0, 9) < 8);
            flush = ($urandom_range(0, 9) < 2);
            RD1 = {$urandom, $urandom};
            RD2 = ($urandom_range(0, 7) == 0) ? RD1 :
                  (($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom});
            PCaddr = {$urandom, $urandom};
            se = $urandom_range(0, 1) ? {$urandom, $urandom} : W'($urandom_range(0, 80));
            Rn = idx[$urandom_range(0, 4)]; Rm = idx[$urandom_range(0, 4)];
            Rd = 5'($urandom); mem_Rd = idx[$urandom_range(0, 4)]; wb_Rd = idx[$urandom_range(0, 4)];
            mem_RegWrite = 1'($urandom); wb_RegWrite = 1'($urandom);
            mem_fwd_data = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            wb_fwd_data = {$urandom, $urandom};
            cntrl_EX = 6'($urandom); cntrl_M = 5'($urandom); cntrl_WB = 2'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage of the pipelined LEGv8 core, directly downstream of the ID/EX register; consumes its outputs.
- Contains the operand forwarding muxes, ALU/shifter, the branch-target adder, the architectural NZVC flag register, and the EX/MEM pipeline register that feeds the MEM stage.
- All results are registered.

Parameters:
- W, 64, datapath width.
- XZR, 31, register index that is never forwarded (reads as zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  stall control; 0 = hold EX/MEM register and flags.
- flush  in  1  1 = load a bubble into EX/MEM.
- RD1, RD2, PCaddr, se  in  W each  ID/EX data fields.
- Rn, Rm, Rd  in  5 each  ID/EX register indices.
- cntrl_EX  in  6  {ALUsrc, ShiftDir, FlagEn, ALUOp[2:0]}.
- cntrl_M  in  5  {MemRead, MemWrite, UBranch, Branch, Brsel}.
- cntrl_WB  in  2  {RegWrite, MemtoReg}.
- mem_fwd_data  in  W  result held in EX/MEM, for forwarding.
- mem_Rd  in  5  destination index held in EX/MEM.
- mem_RegWrite  in  1  RegWrite held in EX/MEM.
- wb_fwd_data  in  W  final writeback value.
- wb_Rd  in  5  writeback destination index.
- wb_RegWrite  in  1  writeback RegWrite.
- alu_result_o  out  W  registered ALU result.
- store_data_o  out  W  registered forwarded B operand.
- br_target_o  out  W  registered PCaddr + (se<<2).
- zero_o  out  1  registered (forwarded B operand == 0), for CBZ.
- flags_o  out  4  architectural NZVC register.
- Rd_o  out  5  registered destination index.
- cntrl_M_o  out  5  registered M controls.
- cntrl_WB_o  out  2  registered WB controls.

Behaviour:
- Reset: every output and the flag register go to 0 immediately on rst high, independent of clk.
- Forward A:
  - mem_fwd_data if mem_RegWrite && mem_Rd==Rn && Rn!=XZR.
  - else wb_fwd_data if wb_RegWrite && wb_Rd==Rn && Rn!=XZR.
  - else RD1.
  - MEM has priority over WB when both match.
- Forward B: same rule using Rm and RD2. Result is fwdB.
- ALU B input: se when ALUsrc=1, else fwdB.
- ALUOp:
  - 000 pass B.
  - 001 result 0 (reserved).
  - 010 A+B.
  - 011 A-B (A + ~B + 1).
  - 100 A&B.
  - 101 A|B.
  - 110 A^B.
  - 111 shift A by se[5:0]; ShiftDir 0 = LSL, 1 = LSR (logical, zero-fill).
- Flags:
  - N = result[W-1].
  - Z = (result==0).
  - C = carry-out for add/sub, else 0.
  - V = signed overflow for add/sub, else 0.
  - Register updates on a clock edge only when enable=1, FlagEn=1 and flush=0.
- Branch target: PCaddr + {se[W-3:0],2'b00}, wrap modulo 2^W.
- EX/MEM register:
  - At the rising edge with enable=1, captures alu result, fwdB, br target, (fwdB==0), Rd, cntrl_M, cntrl_WB.
  - Latency is 1 cycle from the ID/EX outputs.
- flush=1 with enable=1:
  - cntrl_M_o and cntrl_WB_o load 0.
  - Data fields still load.
  - Flags are not updated.
- enable=0: all registers hold, including flags. flush is ignored while enable=0.
- Rn/Rm==XZR: never forwarded, even if mem_Rd==31 with RegWrite set.
- Rst asserted mid-stall or mid-flush: reset wins.

Test Plan:
- Reset: assert rst between edges with outputs nonzero -> all outputs and flags_o==0 before the next edge.
- Forwarding: ADD with RD1=5, RD2=7, no match -> alu_result_o=12 next cycle. Same op with mem_RegWrite=1, mem_Rd=Rn, mem_fwd_data=100 and a WB match on Rn with 200 -> 107 (MEM priority). Rn=31 with a matching mem_Rd=31 -> uses RD1.
- Flags: SUB, A=3, B=5, FlagEn=1 -> result 0xFFFF_FFFF_FFFF_FFFE, flags_o=N1 Z0 C0 V0. SUB 5-5 -> Z1 C1. ADD 0x7FFF..F + 1 -> N1 V1.
- Shift: ALUOp=111, A=1, se[5:0]=63, ShiftDir=0 -> 0x8000_0000_0000_0000. ShiftDir=1, A=0x8000..0 -> 1.
- Stall: enable=0 for 3 cycles while inputs change -> all outputs and flags constant. enable=1 -> new values after 1 edge.
- Flush: flush=1 with cntrl_M=5'b11111, cntrl_WB=2'b11, FlagEn=1 -> cntrl_M_o=0, cntrl_WB_o=0, flags unchanged. Separately, PCaddr=0x100, se=-1 -> br_target_o=0xFC.
